// File: rtl/pifo_sched_pkg.sv
// Shared widths, state encoding and packet limit for the PIFO scheduler read path.
package pifo_sched_pkg;

    localparam int ADDR_W            = 12;
    localparam int DATA_W            = 256;
    localparam int KEEP_W            = DATA_W / 8;
    localparam int TUSER_W           = 128;
    localparam int PIFO_W            = 32;
    localparam int MAX_PKT_WORDS_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } rd_state_e;

endpackage

// File: rtl/pkt_dequeue_reader_if.sv
// Descriptor, packet-buffer read port and AXI4-Stream output of the dequeue reader.
interface pkt_dequeue_reader_if #(
    parameter int ADDR_WIDTH  = pifo_sched_pkg::ADDR_W,
    parameter int DATA_WIDTH  = pifo_sched_pkg::DATA_W,
    parameter int TUSER_WIDTH = pifo_sched_pkg::TUSER_W,
    parameter int PIFO_WIDTH  = pifo_sched_pkg::PIFO_W
) ();

    logic                      s_desc_valid;
    logic                      s_desc_ready;
    logic [ADDR_WIDTH-1:0]     s_desc_addr;

    logic                      m_buf_rd_first_word_en;
    logic [ADDR_WIDTH-1:0]     m_buf_rd_pkt_sop_addr;
    logic                      m_buf_rd_en;

    logic [DATA_WIDTH-1:0]     s_buf_tdata;
    logic [DATA_WIDTH/8-1:0]   s_buf_tkeep;
    logic                      s_buf_tlast;
    logic [TUSER_WIDTH-1:0]    s_buf_tuser;
    logic [PIFO_WIDTH-1:0]     s_buf_tpifo;

    logic [DATA_WIDTH-1:0]     m_axis_tdata;
    logic [DATA_WIDTH/8-1:0]   m_axis_tkeep;
    logic                      m_axis_tlast;
    logic [TUSER_WIDTH-1:0]    m_axis_tuser;
    logic [PIFO_WIDTH-1:0]     m_axis_tpifo;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;

    modport master (
        input  s_desc_valid, s_desc_addr,
        output s_desc_ready,
        output m_buf_rd_first_word_en, m_buf_rd_pkt_sop_addr, m_buf_rd_en,
        input  s_buf_tdata, s_buf_tkeep, s_buf_tlast, s_buf_tuser, s_buf_tpifo,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tpifo,
        output m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        output s_desc_valid, s_desc_addr,
        input  s_desc_ready,
        input  m_buf_rd_first_word_en, m_buf_rd_pkt_sop_addr, m_buf_rd_en,
        output s_buf_tdata, s_buf_tkeep, s_buf_tlast, s_buf_tuser, s_buf_tpifo,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tpifo,
        input  m_axis_tvalid,
        output m_axis_tready
    );

endinterface

// File: rtl/axis_skid_fifo2.sv
// Two-entry FIFO with a registered head; push and pop may coincide even when full.
module axis_skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       count_r;
    logic             push_s;
    logic             pop_s;

    assign m_valid = (count_r != 2'd0);
    assign s_ready = (count_r != 2'd2) || m_ready;
    assign push_s  = s_valid && s_ready;
    assign pop_s   = m_valid && m_ready;
    assign m_data  = head_r;
    assign count   = count_r;

    // Head/tail storage; the head always presents the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        head_r  <= s_data;
                        count_r <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_r <= s_data;
                    end else if (push_s) begin
                        tail_r  <= s_data;
                        count_r <= 2'd2;
                    end else if (pop_s) begin
                        count_r <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_r <= tail_r;
                        if (push_s) begin
                            tail_r <= s_data;
                        end else begin
                            count_r <= 2'd1;
                        end
                    end
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pkt_dequeue_reader.sv
// Read-side controller of the PIFO packet buffer: turns one SOP descriptor into
// buffer read commands and an AXI4-Stream packet with full backpressure.
module pkt_dequeue_reader
    import pifo_sched_pkg::*;
#(
    parameter int ADDR_WIDTH           = ADDR_W,
    parameter int C_M_AXIS_DATA_WIDTH  = DATA_W,
    parameter int C_M_AXIS_TUSER_WIDTH = TUSER_W,
    parameter int C_M_AXIS_PIFO_WIDTH  = PIFO_W,
    parameter int MAX_PKT_WORDS        = MAX_PKT_WORDS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    pkt_dequeue_reader_if.master bus,
    output logic [31:0]          stat_pkt_count,
    output logic [31:0]          stat_word_count,
    output logic                 err_overlength
);

    localparam int KEEP_WIDTH = C_M_AXIS_DATA_WIDTH / 8;
    localparam int PAYLOAD_W  = 1 + KEEP_WIDTH + C_M_AXIS_DATA_WIDTH
                                + C_M_AXIS_TUSER_WIDTH + C_M_AXIS_PIFO_WIDTH;
    localparam int CNT_W      = $clog2(MAX_PKT_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_WORDS - 1);

    rd_state_e             state_r;
    rd_state_e             state_next_s;
    logic [ADDR_WIDTH-1:0] sop_addr_r;
    logic [CNT_W-1:0]      word_cnt_r;
    logic [31:0]           pkt_cnt_r;
    logic [31:0]           word_total_r;
    logic                  err_r;

    logic                  fifo_s_ready_s;
    logic                  fifo_m_valid_s;
    logic [1:0]            fifo_count_s;
    logic                  unused_fifo_count_s;
    logic [PAYLOAD_W-1:0]  fifo_in_s;
    logic [PAYLOAD_W-1:0]  fifo_out_s;
    logic                  push_s;
    logic                  forced_last_s;
    logic                  eop_s;

    // The buffer output is only trusted in STREAM; a push doubles as the advance command.
    assign push_s        = (state_r == ST_STREAM) && fifo_s_ready_s && !rst;
    assign forced_last_s = (word_cnt_r == LAST_IDX);
    assign eop_s         = bus.s_buf_tlast || forced_last_s;

    assign bus.s_desc_ready           = (state_r == ST_IDLE) && !rst;
    assign bus.m_buf_rd_first_word_en = (state_r == ST_LOAD) && !rst;
    assign bus.m_buf_rd_pkt_sop_addr  = sop_addr_r;
    assign bus.m_buf_rd_en            = push_s;

    assign fifo_in_s = {eop_s, bus.s_buf_tkeep, bus.s_buf_tdata,
                        bus.s_buf_tuser, bus.s_buf_tpifo};
    assign {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata,
            bus.m_axis_tuser, bus.m_axis_tpifo} = fifo_out_s;
    assign bus.m_axis_tvalid = fifo_m_valid_s;
    assign unused_fifo_count_s = ^fifo_count_s;

    assign stat_pkt_count  = pkt_cnt_r;
    assign stat_word_count = word_total_r;
    assign err_overlength  = err_r;

    axis_skid_fifo2 #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (push_s),
        .s_ready (fifo_s_ready_s),
        .s_data  (fifo_in_s),
        .m_valid (fifo_m_valid_s),
        .m_ready (bus.m_axis_tready),
        .m_data  (fifo_out_s),
        .count   (fifo_count_s)
    );

    // Next-state decode for the descriptor/load/stream sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.s_desc_valid) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (push_s && eop_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, latched SOP address, per-packet word counter, statistics and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sop_addr_r   <= {ADDR_WIDTH{1'b0}};
            word_cnt_r   <= {CNT_W{1'b0}};
            pkt_cnt_r    <= 32'd0;
            word_total_r <= 32'd0;
            err_r        <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && bus.s_desc_valid) begin
                sop_addr_r <= bus.s_desc_addr;
            end
            if (state_r == ST_LOAD) begin
                word_cnt_r <= {CNT_W{1'b0}};
            end else if (push_s) begin
                word_cnt_r <= word_cnt_r + CNT_W'(1);
            end
            if (push_s) begin
                word_total_r <= word_total_r + 32'd1;
            end
            if (push_s && eop_s) begin
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end
            // Only a packet that really ran past the limit is an error.
            if (push_s && forced_last_s && !bus.s_buf_tlast) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_dequeue_reader.sv
// Randomized bench for pkt_dequeue_reader: buffer model, packet-level expected queue, timing logs.
module tb_pkt_dequeue_reader;

    localparam int MAXW = 64;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic [127:0] user;
        logic [31:0]  pifo;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stat_pkt_count;
    logic [31:0] stat_word_count;
    logic        err_overlength;

    always #5 clk = ~clk;

    pkt_dequeue_reader_if bus ();

    pkt_dequeue_reader #(
        .MAX_PKT_WORDS (MAXW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .stat_pkt_count  (stat_pkt_count),
        .stat_word_count (stat_word_count),
        .err_overlength  (err_overlength)
    );

    // Packet buffer: output shows the word chosen by the previous cycle's command.
    logic [255:0] mem_data [0:4095];
    logic [31:0]  mem_keep [0:4095];
    logic         mem_last [0:4095];
    logic [127:0] mem_user [0:4095];
    logic [31:0]  mem_pifo [0:4095];
    logic [11:0]  buf_ptr = 12'd0;

    always @(posedge clk) begin
        if (bus.m_buf_rd_first_word_en) buf_ptr <= bus.m_buf_rd_pkt_sop_addr;
        else if (bus.m_buf_rd_en)       buf_ptr <= buf_ptr + 12'd1;
    end

    assign bus.s_buf_tdata = mem_data[buf_ptr];
    assign bus.s_buf_tkeep = mem_keep[buf_ptr];
    assign bus.s_buf_tlast = mem_last[buf_ptr];
    assign bus.s_buf_tuser = mem_user[buf_ptr];
    assign bus.s_buf_tpifo = mem_pifo[buf_ptr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_checks = 0;
    int    n_err    = 0;
    beat_t exp_q[$];
    int    exp_pkts  = 0;
    int    exp_words = 0;
    logic  exp_err   = 1'b0;
    int    rd_cnt = 0, fwe_cnt = 0, overlap_cnt = 0, beat_cnt = 0;
    int    acc_cyc[$], fwe_cyc[$], rd_cyc[$], beat_cyc[$];
    int    ready_mode = 0;
    int    pat_idx = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic fill_pkt(input logic [11:0] sop, input int n, input logic with_last);
        logic [11:0] a;
        for (int i = 0; i < n; i++) begin
            a = sop + 12'(i);
            mem_data[a] = rand256();
            mem_keep[a] = $urandom();
            mem_last[a] = with_last && (i == n - 1);
            mem_user[a] = rand128();
            mem_pifo[a] = $urandom();
        end
    endtask

    // Expected beats: walk the buffer from SOP until tlast, forcing tlast on word MAXW.
    task automatic model_pkt(input logic [11:0] sop);
        beat_t       b;
        logic [11:0] a;
        a = sop;
        for (int i = 0; i < MAXW; i++) begin
            b.data = mem_data[a];
            b.keep = mem_keep[a];
            b.user = mem_user[a];
            b.pifo = mem_pifo[a];
            b.last = mem_last[a] || (i == MAXW - 1);
            exp_q.push_back(b);
            exp_words++;
            if (b.last) begin
                if (!mem_last[a]) exp_err = 1'b1;
                break;
            end
            a = a + 12'd1;
        end
        exp_pkts++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [11:0] a);
        int n;
        n = 0;
        bus.s_desc_valid = 1'b1;
        bus.s_desc_addr  = a;
        forever begin
            @(negedge clk);
            if (bus.s_desc_ready) break;
            n++;
            if (n > 500) begin
                check_eq("desc_timeout", 0, 1);
                break;
            end
        end
        model_pkt(a);
        step();
        bus.s_desc_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(exp_q.size() == 0 && bus.s_desc_ready && !bus.m_axis_tvalid) && n < budget);
        if (n >= budget) check_eq("drain_timeout", 0, 1);
    endtask

    task automatic check_stats(input string tag);
        check_eq({tag, "_pkts"}, stat_pkt_count, exp_pkts);
        check_eq({tag, "_words"}, stat_word_count, exp_words);
        check_eq({tag, "_err"}, err_overlength, exp_err);
    endtask

    // Drives tready once per cycle and watches commands, handshakes and stall stability.
    initial begin
        beat_t        e;
        logic         stall_prev;
        logic [448:0] prev_word;
        logic [448:0] cur_word;
        stall_prev = 1'b0;
        prev_word  = '0;
        bus.m_axis_tready = 1'b1;
        forever begin
            step();
            case (ready_mode)
                0:       bus.m_axis_tready = 1'b1;
                1:       bus.m_axis_tready = 1'($urandom_range(0, 1));
                2: begin
                    bus.m_axis_tready = (pat_idx % 3 == 0);
                    pat_idx++;
                end
                default: bus.m_axis_tready = 1'b0;
            endcase
            @(negedge clk);
            cur_word = {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tpifo,
                        bus.m_axis_tuser, bus.m_axis_tdata};
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (bus.m_buf_rd_first_word_en) begin
                    fwe_cnt++;
                    fwe_cyc.push_back(cyc);
                end
                if (bus.m_buf_rd_en) begin
                    rd_cnt++;
                    rd_cyc.push_back(cyc);
                end
                if (bus.m_buf_rd_first_word_en && bus.m_buf_rd_en) overlap_cnt++;
                if (bus.s_desc_valid && bus.s_desc_ready) acc_cyc.push_back(cyc);
                if (stall_prev) begin
                    check_eq("hold_valid", bus.m_axis_tvalid, 1);
                    check_eq("hold_beat", cur_word, prev_word);
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    beat_cyc.push_back(cyc);
                    beat_cnt++;
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("beat_data", bus.m_axis_tdata, e.data);
                        check_eq("beat_keep", bus.m_axis_tkeep, e.keep);
                        check_eq("beat_last", bus.m_axis_tlast, e.last);
                        check_eq("beat_user", bus.m_axis_tuser, e.user);
                        check_eq("beat_pifo", bus.m_axis_tpifo, e.pifo);
                    end
                end
                stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_word  = cur_word;
            end
        end
    end

    initial begin
        int          t0;
        int          rd0;
        int          bc0;
        int          len;
        rst = 1'b1;
        bus.s_desc_valid = 1'b0;
        bus.s_desc_addr  = 12'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_desc_ready", bus.s_desc_ready, 0);
        check_eq("rst_tvalid", bus.m_axis_tvalid, 0);
        check_eq("rst_fwe", bus.m_buf_rd_first_word_en, 0);
        check_eq("rst_rd_en", bus.m_buf_rd_en, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_tdata", bus.m_axis_tdata, 0);
        check_eq("post_rst_tlast", bus.m_axis_tlast, 0);
        check_eq("post_rst_ready", bus.s_desc_ready, 1);
        check_stats("post_rst");

        // Single 4-word packet, tready held high: exact cycle placement
        step();
        fill_pkt(12'h010, 4, 1'b1);
        acc_cyc.delete(); fwe_cyc.delete(); rd_cyc.delete(); beat_cyc.delete();
        send_desc(12'h010);
        wait_drain(200);
        check_eq("t1_acc_n", acc_cyc.size(), 1);
        t0 = acc_cyc[0];
        check_eq("t1_fwe_n", fwe_cyc.size(), 1);
        check_eq("t1_fwe_cyc", fwe_cyc[0], t0 + 1);
        check_eq("t1_rd_n", rd_cyc.size(), 4);
        check_eq("t1_beat_n", beat_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_rd_cyc", rd_cyc[i], t0 + 2 + i);
            check_eq("t1_beat_cyc", beat_cyc[i], t0 + 3 + i);
        end
        check_eq("t1_sop_addr", bus.m_buf_rd_pkt_sop_addr, 12'h010);
        check_stats("t1");

        // Same packet with tready pattern 1,0,0
        fill_pkt(12'h010, 4, 1'b1);
        pat_idx = 0;
        ready_mode = 2;
        rd0 = rd_cnt;
        send_desc(12'h010);
        wait_drain(300);
        check_eq("t2_rd_n", rd_cnt - rd0, 4);
        check_stats("t2");

        // Back-to-back 1-word and 3-word packets
        ready_mode = 0;
        fill_pkt(12'h020, 1, 1'b1);
        fill_pkt(12'h100, 3, 1'b1);
        acc_cyc.delete();
        bc0 = beat_cnt;
        send_desc(12'h020);
        send_desc(12'h100);
        wait_drain(200);
        check_eq("t3_acc_n", acc_cyc.size(), 2);
        check_eq("t3_acc_gap", acc_cyc[1] - acc_cyc[0], 3);
        check_eq("t3_beats", beat_cnt - bc0, 4);
        check_stats("t3");

        // 70 words without tlast: forced end after MAXW words
        ready_mode = 1;
        fill_pkt(12'h200, 70, 1'b0);
        rd0 = rd_cnt;
        send_desc(12'h200);
        wait_drain(1000);
        check_eq("t4_rd_n", rd_cnt - rd0, MAXW);
        check_eq("t4_err", err_overlength, 1);
        check_eq("t4_idle", bus.s_desc_ready, 1);
        check_stats("t4");

        // Reset while word 2 of a 5-word packet is pushed
        ready_mode = 0;
        fill_pkt(12'h300, 5, 1'b1);
        rd0 = rd_cnt;
        send_desc(12'h300);
        len = 0;
        while (rd_cnt - rd0 < 2 && len < 50) begin
            step();
            len++;
        end
        check_eq("t5_reached_w2", rd_cnt - rd0, 2);
        rst = 1'b1;
        exp_q.delete();
        exp_pkts = 0; exp_words = 0; exp_err = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_tvalid", bus.m_axis_tvalid, 0);
        check_eq("t5_idle", bus.s_desc_ready, 1);
        check_stats("t5_rst");
        step();
        fill_pkt(12'h400, 3, 1'b1);
        send_desc(12'h400);
        wait_drain(200);
        check_stats("t5_after");

        // tready low for 10 cycles at packet start
        ready_mode = 3;
        fill_pkt(12'h500, 6, 1'b1);
        rd0 = rd_cnt;
        beat_cyc.delete();
        send_desc(12'h500);
        repeat (10) step();
        check_eq("t6_rd_held", rd_cnt - rd0, 2);
        check_eq("t6_tvalid", bus.m_axis_tvalid, 1);
        ready_mode = 0;
        wait_drain(200);
        check_eq("t6_rd_n", rd_cnt - rd0, 6);
        check_eq("t6_beat_n", beat_cyc.size(), 6);
        check_eq("t6_no_gaps", beat_cyc[5] - beat_cyc[0], 5);
        check_stats("t6");

        // Random lengths and addresses with random backpressure
        ready_mode = 1;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 8);
            fill_pkt(12'h600 + 12'(k * 16), len, 1'b1);
            send_desc(12'h600 + 12'(k * 16));
        end
        wait_drain(2000);
        check_stats("t7");
        check_eq("cmd_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1);
    end

endmodule
